// File: rtl/cpu_defs.sv
// Shared definitions for the fetch front end: reset vector, nop encoding,
// and the {pc, instruction} entry carried through the fetch queue.
package cpu_defs;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int unsigned WORD_BYTES       = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(WORD_BYTES);
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instruction} entries.
// Flush empties the buffer and wins over a push or pop in the same cycle.
module fetch_fifo
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; only entries between the pointers are ever read out.
    always_ff @(posedge clk) begin
        if (reset_n && w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: issues sequential word reads, buffers returned words with
// their PCs, and hands them to decode; redirects flush everything in flight.
module instruction_fetch_queue
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_pend_pc;
    logic          r_inflight;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit;
    logic          w_full;
    logic          w_empty;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;

    // Buffered plus in-flight words may never exceed DEPTH, so a return always has room.
    assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue  = reset_n & ~redirect_valid & (w_credit < (CW+1)'(DEPTH));

    assign w_push            = r_inflight & ~redirect_valid;
    assign w_push_data.pc    = r_pend_pc;
    assign w_push_data.instr = im_rdata;
    assign w_pop             = ~w_empty & out_ready & ~redirect_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= align_word(redirect_pc);
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= next_pc(r_fetch_pc);
                r_pend_pc  <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assert property (@(posedge clk) disable iff (!reset_n) !(w_push && w_full));

    assign im_req          = w_issue;
    assign im_addr         = r_fetch_pc;
    assign out_valid       = ~w_empty;
    assign out_instruction = w_empty ? NOP_INSTR : w_head.instr;
    assign out_pc          = w_empty ? 32'h0 : w_head.pc;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed and random-redirect checks for the instruction fetch queue.
module tb_instruction_fetch_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_ready;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_key = 32'h0;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .im_req          (im_req),
        .im_addr         (im_addr),
        .im_rdata        (im_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_ready       (out_ready)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ mem_key;
    endfunction

    // Memory answers exactly one cycle after an accepted request.
    always @(posedge clk) im_rdata <= im_req ? mem_f(im_addr) : 32'hDEAD_BEEF;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL reset_im_req got=%b want=0", im_req); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_instruction !== 32'h0) begin n_err++; $display("FAIL reset_out_instr got=%h want=0", out_instruction); end
        n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] ea;
        mem_key = 32'h0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            #1;
            ea = 32'h3000 + 32'(4 * k);
            n_cmp++;
            if (im_req !== 1'b1 || im_addr !== ea) begin
                n_err++; $display("FAIL stream_req k=%0d got req=%b addr=%h want req=1 addr=%h", k, im_req, im_addr, ea);
            end
            n_cmp++;
            if (out_valid !== (k >= 2)) begin
                n_err++; $display("FAIL stream_valid k=%0d got=%b want=%b", k, out_valid, (k >= 2));
            end
            if (k >= 2) begin
                ea = 32'h3000 + 32'(4 * (k - 2));
                n_cmp++;
                if (out_pc !== ea || out_instruction !== ea) begin
                    n_err++; $display("FAIL stream_head k=%0d got pc=%h instr=%h want %h/%h", k, out_pc, out_instruction, ea, ea);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic        er;
        logic [31:0] ea;
        mem_key = 32'hA5A5_0000;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick();
            out_ready = (k >= 8);
            #1;
            er = (k < 4) || (k >= 9);
            ea = (k < 4) ? 32'h3000 + 32'(4 * k) : 32'h3010 + 32'(4 * (k - 9));
            n_cmp++;
            if (im_req !== er || (er && im_addr !== ea)) begin
                n_err++; $display("FAIL stall_req k=%0d got req=%b addr=%h want req=%b addr=%h", k, im_req, im_addr, er, ea);
            end
            n_cmp++;
            if (out_valid !== (k >= 2)) begin
                n_err++; $display("FAIL stall_valid k=%0d got=%b want=%b", k, out_valid, (k >= 2));
            end
            if (k >= 8) begin
                ea = 32'h3000 + 32'(4 * (k - 8));
                n_cmp++;
                if (out_pc !== ea || out_instruction !== (ea ^ mem_key)) begin
                    n_err++; $display("FAIL stall_head k=%0d got pc=%h instr=%h want %h/%h", k, out_pc, out_instruction, ea, ea ^ mem_key);
                end
            end
        end
    endtask

    task automatic test_redirect();
        mem_key = 32'hA5A5_0000;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            redirect_valid = (k == 4);
            redirect_pc    = 32'h0000_4002;
            out_ready      = (k >= 8);
            #1;
            if (k == 4) begin
                n_cmp++;
                if (im_req !== 1'b0 || out_valid !== 1'b1) begin
                    n_err++; $display("FAIL redir_cycle got req=%b valid=%b want req=0 valid=1", im_req, out_valid);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (out_valid !== 1'b0 || out_instruction !== 32'h0 || out_pc !== 32'h0) begin
                    n_err++; $display("FAIL redir_flushed got valid=%b instr=%h pc=%h want 0/0/0", out_valid, out_instruction, out_pc);
                end
                n_cmp++;
                if (im_req !== 1'b1 || im_addr !== 32'h4000) begin
                    n_err++; $display("FAIL redir_first_req got req=%b addr=%h want req=1 addr=00004000", im_req, im_addr);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (out_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h4004) begin
                    n_err++; $display("FAIL redir_second got valid=%b req=%b addr=%h want 0/1/00004004", out_valid, im_req, im_addr);
                end
            end
            if (k >= 7) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== ((k == 9) ? 32'h4004 : 32'h4000) ||
                    out_instruction !== (out_pc ^ mem_key)) begin
                    n_err++; $display("FAIL redir_head k=%0d got valid=%b pc=%h instr=%h want pc=%h", k, out_valid, out_pc, out_instruction, (k == 9) ? 32'h4004 : 32'h4000);
                end
            end
        end
    endtask

    task automatic test_redirect_pop();
        mem_key = 32'h0F0F_0000;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            redirect_valid = (k == 3);
            redirect_pc    = 32'h0000_5000;
            #1;
            if (k == 3) begin
                n_cmp++;
                if (im_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h3004) begin
                    n_err++; $display("FAIL rpop_cycle got req=%b valid=%b pc=%h want 0/1/00003004", im_req, out_valid, out_pc);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (out_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h5000) begin
                    n_err++; $display("FAIL rpop_after got valid=%b req=%b addr=%h want 0/1/00005000", out_valid, im_req, im_addr);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== 32'h5000 || out_instruction !== (32'h5000 ^ mem_key)) begin
                    n_err++; $display("FAIL rpop_head got valid=%b pc=%h instr=%h want 1/00005000", out_valid, out_pc, out_instruction);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        mem_key = 32'h0F0F_0000;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            redirect_valid = (k == 1) || (k == 2);
            redirect_pc    = (k == 1) ? 32'h0000_6000 : 32'h0000_7009;
            #1;
            if (k == 1 || k == 2) begin
                n_cmp++;
                if (im_req !== 1'b0) begin n_err++; $display("FAIL b2b_noreq k=%0d got=%b want=0", k, im_req); end
            end
            if (k == 3) begin
                n_cmp++;
                if (im_req !== 1'b1 || im_addr !== 32'h7008) begin
                    n_err++; $display("FAIL b2b_req got req=%b addr=%h want 1/00007008", im_req, im_addr);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== 32'h7008) begin
                    n_err++; $display("FAIL b2b_head got valid=%b pc=%h want 1/00007008", out_valid, out_pc);
                end
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] ea;
        mem_key = 32'h3C3C_0000;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            redirect_valid = (k == 0);
            redirect_pc    = 32'hFFFF_FFF8;
            #1;
            if (k >= 1 && k <= 4) begin
                ea = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
                n_cmp++;
                if (im_req !== 1'b1 || im_addr !== ea) begin
                    n_err++; $display("FAIL wrap_req k=%0d got req=%b addr=%h want 1/%h", k, im_req, im_addr, ea);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== mem_key) begin
                    n_err++; $display("FAIL wrap_head got valid=%b pc=%h instr=%h want 1/00000000/%h", out_valid, out_pc, out_instruction, mem_key);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        mem_key = 32'h5A5A_0000;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            reset_n = (k != 6);
            #1;
            if (k == 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || im_req !== 1'b0) begin
                    n_err++; $display("FAIL midrst_full got valid=%b req=%b want 1/0", out_valid, im_req);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (im_req !== 1'b0) begin n_err++; $display("FAIL midrst_req got=%b want=0", im_req); end
            end
            if (k == 7) begin
                n_cmp++;
                if (out_valid !== 1'b0 || out_instruction !== 32'h0 || out_pc !== 32'h0) begin
                    n_err++; $display("FAIL midrst_out got valid=%b instr=%h pc=%h want 0/0/0", out_valid, out_instruction, out_pc);
                end
                n_cmp++;
                if (im_req !== 1'b1 || im_addr !== 32'h3000) begin
                    n_err++; $display("FAIL midrst_restart got req=%b addr=%h want 1/00003000", im_req, im_addr);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_fetch;
        logic [31:0] exp_next;
        logic [31:0] tgt;
        logic        redir;
        int          pops;
        mem_key   = 32'h6B1D_0000;
        do_reset();
        exp_fetch = 32'h3000;
        exp_next  = 32'h3000;
        pops      = 0;
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) tick();
            redir          = ($urandom_range(0, 19) == 0);
            tgt            = $urandom;
            redirect_valid = redir;
            redirect_pc    = tgt;
            out_ready      = ($urandom_range(0, 1) == 1);
            #1;
            if (!out_valid) begin
                n_cmp++;
                if (out_pc !== 32'h0 || out_instruction !== 32'h0) begin
                    n_err++; $display("FAIL rnd_empty k=%0d got pc=%h instr=%h want 0/0", k, out_pc, out_instruction);
                end
            end
            if (redir) begin
                n_cmp++;
                if (im_req !== 1'b0) begin n_err++; $display("FAIL rnd_redir_req k=%0d got=%b want=0", k, im_req); end
                exp_fetch = tgt & ~32'h3;
                exp_next  = tgt & ~32'h3;
            end else begin
                if (im_req) begin
                    n_cmp++;
                    if (im_addr !== exp_fetch) begin
                        n_err++; $display("FAIL rnd_addr k=%0d got=%h want=%h", k, im_addr, exp_fetch);
                    end
                    exp_fetch = exp_fetch + 32'h4;
                end
                if (out_valid && out_ready) begin
                    n_cmp++;
                    if (out_pc !== exp_next || out_instruction !== (exp_next ^ mem_key)) begin
                        n_err++; $display("FAIL rnd_pop k=%0d got pc=%h instr=%h want %h/%h", k, out_pc, out_instruction, exp_next, exp_next ^ mem_key);
                    end
                    exp_next = exp_next + 32'h4;
                    pops++;
                end
            end
        end
        n_cmp++;
        if (pops < 200) begin n_err++; $display("FAIL rnd_progress got pops=%0d want>=200", pops); end
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_pc_wrap();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Producer end of the decode-stage instruction path. Sequences PCs, issues word reads to instruction memory, buffers returned words with their PCs in a small FIFO, and presents them to the decoder through a valid/ready handshake. Its output feeds the unsupported-instruction filter in front of decode. Branch/jump redirects from execute flush all buffered and in-flight words.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
RESET_PC, 32'h0000_3000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
im_req  output  1  read request to instruction memory this cycle
im_addr  output  32  word-aligned read address, valid when im_req=1
im_rdata  input  32  read data, valid exactly one cycle after the accepted im_req
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
out_valid  output  1  FIFO head holds a valid instruction
out_instruction  output  32  head instruction; 32'h0000_0000 (nop) when out_valid=0
out_pc  output  32  head PC; 32'h0 when out_valid=0
out_ready  input  1  decoder accepts head this cycle

Behaviour:
- State: fetch_pc[31:0], inflight (1 bit), FIFO of {pc, instruction} with rd_ptr, wr_ptr, count[log2(DEPTH):0].
- Reset (reset_n=0 at edge): fetch_pc=RESET_PC, inflight=0, count=0, pointers 0. Outputs next cycle: im_req=0 during the reset cycle itself (im_req is gated by reset_n), out_valid=0, out_instruction=0, out_pc=0.
- Issue: im_req = reset_n & ~redirect_valid & (count + inflight < DEPTH), using registered count/inflight. im_addr = fetch_pc. On issue: fetch_pc += 4, inflight<=1, record issued PC in pend_pc. No issue: inflight<=0.
- Return: if inflight=1 and no squash, push {pend_pc, im_rdata} at wr_ptr the cycle after issue. Issue and return overlap, sustaining one word per cycle.
- No bypass: a word returned in cycle t appears at out_* in cycle t+1. Fetch-to-output latency is 2 cycles.
- Pop: on out_valid & out_ready, rd_ptr advances. Simultaneous push and pop leave count unchanged. The credit rule guarantees a push never hits a full FIFO; overflow is a design error (assertion).
- out_valid = (count != 0). out_instruction/out_pc are the head entry, or zeros when empty.
- Redirect (highest priority): in the cycle redirect_valid=1:
  - count<=0, rd_ptr<=wr_ptr<=0.
  - Any response returning this cycle is discarded, and inflight<=0.
  - No im_req is issued.
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - A pop in the same cycle is ignored.
  - The first request to redirect_pc goes out in the next cycle. Back-to-back redirects: the last one wins.
- Redirect with a full FIFO or an empty FIFO behaves identically.
- out_ready held 0: fetch stalls after the FIFO fills (count+inflight=DEPTH). fetch_pc holds and nothing is lost.
- Pointer wrap: modulo DEPTH. count is one bit wider to distinguish full from empty.
- PC wrap: 32'hFFFF_FFFC + 4 = 0 (natural overflow, no trap).

Decomposition:
- Shared package (cpu_defs): NOP_INSTR=32'h0, RESET_PC_DEFAULT=32'h0000_3000, WORD_BYTES=4.
- One sub-module: fetch_fifo (parameterised DEPTH, 64-bit entry {pc, instr}, push/pop/flush, count/full/empty).
- Issue/credit and redirect logic stay in the top module.

Test Plan:
- Reset then out_ready=1, memory returns addr as data: im_addr sequence 0x3000, 0x3004, …; out_valid first rises 2 cycles after first im_req; out_pc/out_instruction 0x3000, 0x3004 on consecutive cycles (1 IPC).
- Hold out_ready=0 from reset: exactly 4 im_req pulses (0x3000–0x300C), then im_req=0; count=4. Raise out_ready: heads 0x3000…0x300C in order, fetch resumes at 0x3010.
- Redirect to 0x0000_4002 while 3 entries buffered and one in flight: next cycle out_valid=0 and out_instruction=0. The in-flight word is never output. The next im_addr is 0x4000, whose word appears 2 cycles later.
- Redirect asserted in the same cycle as out_ready with a valid head: pop ignored, FIFO empty afterwards, no im_req that cycle.
- Random out_ready (50%) over 1000 cycles with random redirects: scoreboard checks every output pc = previous pc+4 or the last redirect target, data matches memory, and the FIFO never overflows.
- reset_n=0 asserted mid-stream with full FIFO: following cycle out_valid=0, im_req resumes at 0x3000 once reset_n=1.
